// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request/response responder.
// Holds the default operand and opcode widths, the opcode numbering,
// and the responder FSM state type.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_SEL_W = 4;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_AND = 1;
  localparam int unsigned OP_OR  = 2;
  localparam int unsigned OP_XOR = 3;
  localparam int unsigned OP_SUB = 4;
  localparam int unsigned OP_MUL = 5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle,
// LSB first, WIDTH iterations.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin (single-cycle pulse)
//   a, b       : multiplicand, multiplier
//   done       : high during the final iteration cycle; product is final then
//   product    : 2*WIDTH-bit result, valid while done is high
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  // product is the accumulator after the current iteration's add, so the
  // caller can register the final value at the last iteration's edge.
  always_comb begin
    done    = busy && (cnt == CNT_W'(WIDTH - 1));
    product = mplier[0] ? acc + mcand : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= (2*WIDTH)'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked ALU responder: accepts one (A, B, Sel) request over a
// valid/ready channel, executes it and returns C with Carry/Zero/Err over a
// valid/ready response channel. Single-cycle ops are computed inline; MUL
// runs on the iterative shift-add multiplier.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid, req_ready : request handshake; A, B, Sel sampled on transfer
//   rsp_valid, rsp_ready : response handshake; C and flags held until taken
//   C                    : 2*WIDTH-bit zero-extended result
//   Carry, Zero, Err     : carry/borrow, C==0, illegal opcode
module alu_seq_responder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SEL_W = DEFAULT_SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SEL_W-1:0]   Sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] C,
  output logic               Carry,
  output logic               Zero,
  output logic               Err
);

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] res;
  logic               res_carry;
  logic               res_err;

  // Operands are consumed straight from the inputs at the accepting edge:
  // single-cycle results are registered there and the multiplier loads its
  // own operand registers on start, so later input changes have no effect.
  always_comb begin
    accept    = req_valid && req_ready;
    mul_start = accept && (state == IDLE) && (Sel == SEL_W'(OP_MUL));
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    res       = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (Sel)
      SEL_W'(OP_ADD): begin
        res       = (2*WIDTH)'(sum);
        res_carry = sum[WIDTH];
      end
      SEL_W'(OP_AND): res = (2*WIDTH)'(A & B);
      SEL_W'(OP_OR):  res = (2*WIDTH)'(A | B);
      SEL_W'(OP_XOR): res = (2*WIDTH)'(A ^ B);
      SEL_W'(OP_SUB): begin
        res       = (2*WIDTH)'(diff[WIDTH-1:0]);
        res_carry = diff[WIDTH];  // borrow: set exactly when A < B
      end
      SEL_W'(OP_MUL): res = '0;   // produced by the multiplier
      default:        res_err = 1'b1;
    endcase
  end

  alu_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (A),
    .b      (B),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      C         <= '0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (Sel == SEL_W'(OP_MUL)) begin
              state <= MUL;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              C         <= res;
              Carry     <= res_carry;
              Zero      <= (res == '0);
              Err       <= res_err;
            end
          end else begin
            // Raises req_ready on the first edge after reset release.
            req_ready <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            C         <= mul_product;
            Carry     <= 1'b0;
            Zero      <= (mul_product == '0);
            Err       <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
